// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the fetch / decode boundary: default datapath width,
// the canonical NOP encoding, and width helpers for queue pointers and
// occupancy counters. The fetcher and decoder import this package as well.
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Pointer width for a power-of-two queue; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width: must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Decode-side receiver for the fetch stage. Accepts (pc, inst) pairs into a
// small in-order FIFO and presents the oldest entry to the decoder. full_ is
// the backpressure signal to the fetcher. A flush (branch misprediction)
// discards every stored entry and the entry offered in the same cycle.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards the offered entry combinationally
//   to the outputs; if the decoder consumes it in that cycle it is never
//   written to storage.
//
// Ports:
//   _clk     clock, posedge
//   _reset   asynchronous active-high reset
//   _pc      pc offered by the fetcher          [XLEN]
//   _inst    instruction offered by the fetcher [XLEN]
//   _valid   fetcher offers _pc/_inst this cycle
//   _flush   misprediction: drop everything
//   _deq     decoder consumes the head entry
//   pc_      head entry pc (0 when empty)
//   inst_    head entry instruction (NOP when empty)
//   valid_   head entry present
//   full_    count_ == DEPTH
//   count_   number of occupied entries         [clog2(DEPTH)+1]
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                          _clk,
  input  logic                          _reset,
  input  logic [XLEN-1:0]               _pc,
  input  logic [XLEN-1:0]               _inst,
  input  logic                          _valid,
  input  logic                          _flush,
  input  logic                          _deq,
  output logic [XLEN-1:0]               pc_,
  output logic [XLEN-1:0]               inst_,
  output logic                          valid_,
  output logic                          full_,
  output logic [cnt_width(DEPTH)-1:0]   count_
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic              q_valid;
  logic              byp_consume;
  logic              enq;
  logic              deq;
  logic [XLEN-1:0]   head_pc;
  logic [XLEN-1:0]   head_inst;

  assign q_valid = (count_ != '0);
  assign full_   = (count_ == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp_hit;
  assign byp_hit     = !q_valid && _valid && !_flush;
  assign byp_consume = byp_hit && _deq;
`else
  assign byp_consume = 1'b0;
`endif

  // A bypassed-and-consumed entry never touches storage.
  assign enq = _valid && !full_ && !_flush && !byp_consume;
  assign deq = _deq && q_valid && !_flush;

  assign {head_pc, head_inst} = mem[rd_ptr];

  // ---- storage write (data, not reset) ----
  always_ff @(posedge _clk) begin
    if (enq) begin
      mem[wr_ptr] <= {_pc, _inst};
    end
  end

  // ---- pointer / occupancy update ----
  always_ff @(posedge _clk or posedge _reset) begin
    if (_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count_ <= '0;
    end else if (_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count_ <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_ <= count_ + CNT_W'(1);
        2'b01:   count_ <= count_ - CNT_W'(1);
        default: count_ <= count_;
      endcase
    end
  end

  // ---- head presentation ----
  always_comb begin
    valid_ = q_valid;
    pc_    = q_valid ? head_pc : '0;
    inst_  = q_valid ? head_inst : XLEN'(INST_NOP);
`ifdef FETCH_QUEUE_BYPASS_EN
    if (byp_hit) begin
      valid_ = 1'b1;
      pc_    = _pc;
      inst_  = _inst;
    end
`endif
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Decode-side receiver for the fetch stage. It accepts (pc, inst) pairs from the fetcher into a small in-order FIFO and presents the oldest entry to the decoder. It drives the backpressure (blocked) signal back to the fetcher. On a branch misprediction it discards every entry, since each one was fetched down the wrong path.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
XLEN, 32, pc and instruction width in bits.

Ports:
_clk  input  1  clock; all state updates on posedge.
_reset  input  1  asynchronous, active-high reset.
_pc  input  XLEN  pc of the instruction being offered by the fetcher.
_inst  input  XLEN  instruction word being offered.
_valid  input  1  fetcher offers _pc/_inst this cycle.
_flush  input  1  misprediction; driven from the fetcher's prediction-invalid output.
_deq  input  1  decoder consumes the head entry this cycle.
pc_  output  XLEN  head entry pc.
inst_  output  XLEN  head entry instruction; NOP (0x00000013) when valid_=0.
valid_  output  1  head entry present.
full_  output  1  count==DEPTH; wired to the fetcher's decoder-blocked input.
count_  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, active-high):
  - rd_ptr = wr_ptr = 0, count_ = 0, valid_ = 0, full_ = 0.
  - pc_ = 0, inst_ = NOP.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- enq = _valid && !full_ && !_flush. Full blocks enqueue even when _deq is asserted in the same cycle; there is no full-bypass.
- deq = _deq && valid_ && !_flush. _deq while empty is ignored; no underflow.
- Posedge update:
  - enq writes mem[wr_ptr] and increments wr_ptr.
  - deq increments rd_ptr.
  - count_ += enq - deq. Simultaneous enq and deq leaves count_ unchanged.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by count_, not by pointer comparison.
- _flush has priority over everything:
  - Next edge: count_ = 0, rd_ptr = wr_ptr = 0.
  - The same-cycle _valid entry is dropped, since it is wrong-path.
  - The same-cycle _deq has no effect.
- Outputs are registered-state derived:
  - pc_/inst_ = mem[rd_ptr].
  - valid_ = (count_!=0).
  - full_ = (count_==DEPTH).
- Latency: an entry enqueued at edge N is visible on pc_/inst_ after edge N (one cycle), unless bypass is enabled.
- Data in mem is not cleared on flush or reset; only valid_ gates it. inst_ is forced to NOP when !valid_.
- Order preserved strictly; no reordering, no duplication.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when count_==0, !_flush and _valid, the block drives outputs combinationally from the input:
  - pc_ = _pc, inst_ = _inst, valid_ = 1.
  - If _deq is also asserted, the entry is consumed and never written; count_ stays 0.
  - If _deq is not asserted, it is enqueued normally.
- Undefined: outputs come from storage only; minimum latency is one cycle.

Decomposition:
- Shared package holds:
  - XLEN default.
  - NOP encoding constant INST_NOP = 32'h00000013.
  - clog2-based width helper for count/pointer widths, shared with the fetcher and decoder.
- No sub-module. Storage is an inline register array of DEPTH x (2*XLEN), with pointer and counter logic in this module.

Test Plan:
- Reset then idle: _reset pulse -> valid_=0, full_=0, count_=0, inst_=00000013; _deq=1 for 3 cycles -> count_ stays 0.
- Fill/drain, DEPTH=4:
  - Stimulus: enqueue pc 0x100,0x104,0x108,0x10C with _deq=0.
  - After 4th edge: full_=1, count_=4.
  - 5th offer pc 0x110 with _valid=1 -> not accepted, count_ stays 4.
  - Drain: pc_ sequence is 0x100,0x104,0x108,0x10C, then valid_=0.
- Simultaneous enq/deq at count_=2 -> count_ stays 2, head advances; 10 such cycles prove wrap-around keeps order.
- Flush with concurrent traffic:
  - Stimulus: count_=3, _flush=1 with _valid=1 (pc 0x200) and _deq=1.
  - Next edge: count_=0, valid_=0.
  - Following enqueue of pc 0x300 appears as head.
- Async reset mid-stream: assert _reset between edges with count_=2 -> valid_=0 and count_=0 before the next posedge.
- Bypass (FETCH_QUEUE_BYPASS_EN):
  - Empty queue, _valid=1 with pc 0x400 and _deq=1 -> same-cycle pc_=0x400, valid_=1; after the edge, count_=0.
  - Without the macro: same stimulus -> valid_=0 that cycle, count_=1 after the edge.
